// File: rtl/chase_game_ctrl.sv
// Game logic for the cat/dog/rat chase on the 8x8 dot-matrix: patrol, rat steering, crossings, progress bar.
// Optional macro DEBOUNCE_EN adds a DEB_MS-cycle stability filter on every button.
module chase_game_ctrl #(
  parameter int CAT_PERIOD = 300,
  parameter int DOG_PERIOD = 500,
  parameter int HIT_MS     = 1000
`ifdef DEBOUNCE_EN
  , parameter int DEB_MS   = 20
`endif
) (
  input  logic        clk_1kHz,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_go,
  output logic [7:0]  colred_cat,
  output logic [7:0]  colgreen_dog,
  output logic [7:0]  col_rat,
  output logic [15:0] led
);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, WIN} state_t;

  localparam int CAT_W = $clog2(CAT_PERIOD);
  localparam int DOG_W = $clog2(DOG_PERIOD);
  localparam int HIT_W = $clog2(HIT_MS);

  logic [2:0] btn_raw;
  logic [2:0] sync1, sync2, edge_ref, pulse;
  logic       left_p, right_p, go_p;

  assign btn_raw = {btn_go, btn_right, btn_left};

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DEB_W = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

  logic [DEB_W-1:0] deb_cnt [3];
  logic [2:0]       stable;

  // A level is accepted only after it has differed from the accepted one for DEB_MS cycles in a row.
  always_ff @(posedge clk_1kHz) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        deb_cnt[i] <= '0;
        stable[i]  <= 1'b0;
      end else if (sync2[i] == stable[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == DEB_W'(DEB_MS - 1)) begin
        deb_cnt[i] <= '0;
        stable[i]  <= sync2[i];
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (rst) edge_ref <= '0;
    else     edge_ref <= stable;
  end

  assign pulse = stable & ~edge_ref;
`else
  always_ff @(posedge clk_1kHz) begin
    if (rst) edge_ref <= '0;
    else     edge_ref <= sync2;
  end

  assign pulse = sync2 & ~edge_ref;
`endif

  assign left_p  = pulse[0];
  assign right_p = pulse[1];
  assign go_p    = pulse[2];

  function automatic logic [7:0] pos_mask(input logic [2:0] pos);
    return 8'b0000_0011 << pos;
  endfunction

  // Returns {new_dir_up, new_pos}; the 2-wide block bounces off columns 0 and 6.
  function automatic logic [3:0] step_pos(input logic [2:0] pos, input logic up);
    if (up) return (pos == 3'd6) ? {1'b0, 3'd5} : {1'b1, pos + 3'd1};
    else    return (pos == 3'd0) ? {1'b1, 3'd1} : {1'b0, pos - 3'd1};
  endfunction

  state_t           state, state_n;
  logic [2:0]       cat_pos, cat_pos_n, dog_pos, dog_pos_n, rat_pos, rat_pos_n;
  logic             cat_up, cat_up_n, dog_up, dog_up_n;
  logic [CAT_W-1:0] cat_tmr, cat_tmr_n;
  logic [DOG_W-1:0] dog_tmr, dog_tmr_n;
  logic [HIT_W-1:0] hit_cnt, hit_cnt_n;
  logic [15:0]      led_n;
  logic             overlap;

  always_ff @(posedge clk_1kHz) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Overlap is judged on the patterns currently on display, before any same-cycle move.
  always_comb begin
    state_n   = state;
    cat_pos_n = cat_pos;
    cat_up_n  = cat_up;
    dog_pos_n = dog_pos;
    dog_up_n  = dog_up;
    rat_pos_n = rat_pos;
    cat_tmr_n = cat_tmr;
    dog_tmr_n = dog_tmr;
    hit_cnt_n = '0;
    led_n     = led;
    overlap   = |(col_rat & (colred_cat | colgreen_dog));

    if (state == PLAY || state == HIT) begin
      if (cat_tmr == CAT_W'(CAT_PERIOD - 1)) begin
        cat_tmr_n             = '0;
        {cat_up_n, cat_pos_n} = step_pos(cat_pos, cat_up);
      end else begin
        cat_tmr_n = cat_tmr + 1'b1;
      end
      if (dog_tmr == DOG_W'(DOG_PERIOD - 1)) begin
        dog_tmr_n             = '0;
        {dog_up_n, dog_pos_n} = step_pos(dog_pos, dog_up);
      end else begin
        dog_tmr_n = dog_tmr + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (go_p) state_n = PLAY;
      end
      PLAY: begin
        if (go_p) begin
          if (overlap) begin
            led_n   = {1'b0, led[15:1]};
            state_n = HIT;
          end else begin
            led_n = {led[14:0], 1'b1};
            if (led_n == 16'hffff) state_n = WIN;
          end
        end else if (left_p && !right_p) begin
          if (rat_pos != 3'd0) rat_pos_n = rat_pos - 3'd1;
        end else if (right_p && !left_p) begin
          if (rat_pos != 3'd6) rat_pos_n = rat_pos + 3'd1;
        end
      end
      HIT: begin
        if (hit_cnt == HIT_W'(HIT_MS - 1)) begin
          rat_pos_n = 3'd3;
          state_n   = PLAY;
        end else begin
          hit_cnt_n = hit_cnt + 1'b1;
        end
      end
      WIN: begin
        if (go_p) begin
          led_n     = '0;
          cat_pos_n = 3'd0;
          cat_up_n  = 1'b1;
          dog_pos_n = 3'd6;
          dog_up_n  = 1'b0;
          rat_pos_n = 3'd3;
          cat_tmr_n = '0;
          dog_tmr_n = '0;
          state_n   = PLAY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      cat_pos      <= 3'd0;
      cat_up       <= 1'b1;
      dog_pos      <= 3'd6;
      dog_up       <= 1'b0;
      rat_pos      <= 3'd3;
      cat_tmr      <= '0;
      dog_tmr      <= '0;
      hit_cnt      <= '0;
      led          <= '0;
      colred_cat   <= 8'h03;
      colgreen_dog <= 8'hC0;
      col_rat      <= 8'h18;
    end else begin
      cat_pos      <= cat_pos_n;
      cat_up       <= cat_up_n;
      dog_pos      <= dog_pos_n;
      dog_up       <= dog_up_n;
      rat_pos      <= rat_pos_n;
      cat_tmr      <= cat_tmr_n;
      dog_tmr      <= dog_tmr_n;
      hit_cnt      <= hit_cnt_n;
      led          <= led_n;
      colred_cat   <= pos_mask(cat_pos_n);
      colgreen_dog <= pos_mask(dog_pos_n);
      col_rat      <= (state_n == HIT) ? 8'h00 : pos_mask(rat_pos_n);
    end
  end

endmodule

// File: tb/tb_chase_game_ctrl.sv
// Directed bench for chase_game_ctrl: vector table for rat steering plus hand-written game sequences.
// Expectations follow DEBOUNCE_EN when the macro is defined for the build.
module tb_chase_game_ctrl;

  logic        clk_1kHz = 1'b0;
  logic        rst = 1'b1;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_go = 1'b0;
  logic [7:0]  colred_cat, colgreen_dog, col_rat;
  logic [15:0] led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef DEBOUNCE_EN
  localparam int LAT = 23;
  localparam int HOLD = 24;
  localparam int PER = 48;
`else
  localparam int LAT = 3;
  localparam int HOLD = 2;
  localparam int PER = 8;
`endif

  // Patrol model: 0 = idle at reset positions, 1 = running since go_edge, 2 = frozen after frozen_n cycles.
  int pmode = 0;
  int go_edge = 0;
  int frozen_n = 0;
  int press_at = 0;
  int hit_edge = 0;

  typedef struct {
    logic       left;
    logic       right;
    logic       go;
    logic [7:0] exp_rat;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [17];

  chase_game_ctrl dut (
    .clk_1kHz     (clk_1kHz),
    .rst          (rst),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_go       (btn_go),
    .colred_cat   (colred_cat),
    .colgreen_dog (colgreen_dog),
    .col_rat      (col_rat),
    .led          (led)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  always @(posedge clk_1kHz) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int bouncePos(int start, bit upIn, int steps);
    int p = start;
    bit up = upIn;
    for (int k = 0; k < steps; k++) begin
      if (up) begin
        if (p == 6) begin up = 1'b0; p = 5; end
        else p++;
      end else begin
        if (p == 0) begin up = 1'b1; p = 1; end
        else p--;
      end
    end
    return p;
  endfunction

  function automatic logic [7:0] blockOf(int p);
    logic [7:0] b;
    b = 8'h03;
    return b << p;
  endfunction

  function automatic int elapsed();
    if (pmode == 1) return cyc - go_edge;
    if (pmode == 2) return frozen_n;
    return 0;
  endfunction

  function automatic logic [7:0] expCat();
    return blockOf(bouncePos(0, 1'b1, elapsed() / 300));
  endfunction

  function automatic logic [7:0] expDog();
    return blockOf(bouncePos(6, 1'b0, elapsed() / 500));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1kHz);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic g);
    press_at  = cyc;
    btn_left  = l;
    btn_right = r;
    btn_go    = g;
    tick(HOLD);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_go    = 1'b0;
    tick(PER - HOLD);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ec, input logic [7:0] ed,
                             input logic [7:0] er, input logic [15:0] el);
    checks++;
    if (colred_cat !== ec || colgreen_dog !== ed || col_rat !== er || led !== el) begin
      failures++;
      $display("[TB] FAIL %s @cyc %0d: got cat=%h dog=%h rat=%h led=%h, expected cat=%h dog=%h rat=%h led=%h",
               name, cyc, colred_cat, colgreen_dog, col_rat, led, ec, ed, er, el);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_go = 1'b0;
    tick(2);
    rst = 1'b0;
    pmode = 0;
  endtask

  task automatic startPlay();
    applyStimulus(1'b0, 1'b0, 1'b1);
    go_edge = press_at + LAT;
    pmode = 1;
  endtask

  initial begin
    vecs = '{
      '{1'b1, 1'b0, 1'b0, 8'h0C, 16'h0000}, '{1'b1, 1'b0, 1'b0, 8'h06, 16'h0000},
      '{1'b1, 1'b0, 1'b0, 8'h03, 16'h0000}, '{1'b1, 1'b0, 1'b0, 8'h03, 16'h0000},
      '{1'b1, 1'b0, 1'b0, 8'h03, 16'h0000}, '{1'b0, 1'b1, 1'b0, 8'h06, 16'h0000},
      '{1'b0, 1'b1, 1'b0, 8'h0C, 16'h0000}, '{1'b0, 1'b1, 1'b0, 8'h18, 16'h0000},
      '{1'b0, 1'b1, 1'b0, 8'h30, 16'h0000}, '{1'b0, 1'b1, 1'b0, 8'h60, 16'h0000},
      '{1'b0, 1'b1, 1'b0, 8'hC0, 16'h0000}, '{1'b0, 1'b1, 1'b0, 8'hC0, 16'h0000},
      '{1'b0, 1'b1, 1'b0, 8'hC0, 16'h0000}, '{1'b1, 1'b1, 1'b0, 8'hC0, 16'h0000},
      '{1'b1, 1'b0, 1'b0, 8'h60, 16'h0000}, '{1'b1, 1'b0, 1'b0, 8'h30, 16'h0000},
      '{1'b1, 1'b0, 1'b0, 8'h18, 16'h0000}
    };

    // Reset and idle hold
    tick(2);
    rst = 1'b0;
    pmode = 0;
    checkOutput("reset", 8'h03, 8'hC0, 8'h18, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick(250);
      checkOutput("idle_hold", 8'h03, 8'hC0, 8'h18, 16'h0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_left_ignored", 8'h03, 8'hC0, 8'h18, 16'h0000);

    // Patrol timing and bounce
    startPlay();
    waitUntil(go_edge + 299);
    checkOutput("cat_before_step", 8'h03, 8'hC0, 8'h18, 16'h0000);
    waitUntil(go_edge + 300);
    checkOutput("cat_first_step", 8'h06, 8'hC0, 8'h18, 16'h0000);
    waitUntil(go_edge + 500);
    checkOutput("dog_first_step", 8'h06, 8'h60, 8'h18, 16'h0000);
    waitUntil(go_edge + 1800);
    checkOutput("cat_at_top", 8'hC0, 8'h18, 8'h18, 16'h0000);
    waitUntil(go_edge + 2100);
    checkOutput("cat_bounce", 8'h60, 8'h0C, 8'h18, 16'h0000);

    rst = 1'b1;
    btn_go = 1'b1;
    btn_right = 1'b1;
    tick(2);
    rst = 1'b0;
    btn_go = 1'b0;
    btn_right = 1'b0;
    pmode = 0;
    checkOutput("rst_priority", 8'h03, 8'hC0, 8'h18, 16'h0000);

    // Rat steering table
    doReset();
    startPlay();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].left, vecs[i].right, vecs[i].go);
      checkOutput($sformatf("rat_table[%0d]", i), expCat(), expDog(), vecs[i].exp_rat, vecs[i].exp_led);
    end

    // Crossings, hit blanking and led shift-down
    doReset();
    startPlay();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("cross_clear", expCat(), expDog(), 8'h18, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("cross_go_drops_move", expCat(), expDog(), 8'h18, 16'h0003);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rat_to_zero", expCat(), expDog(), 8'h03, 16'h0003);
    applyStimulus(1'b0, 1'b0, 1'b1);
    hit_edge = press_at + LAT;
    checkOutput("hit_enter", expCat(), expDog(), 8'h00, 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hit_ignores_btn", expCat(), expDog(), 8'h00, 16'h0001);
    waitUntil(hit_edge + 999);
    checkOutput("hit_last_blank", expCat(), expDog(), 8'h00, 16'h0001);
    tick(1);
    checkOutput("hit_exit", expCat(), expDog(), 8'h18, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b1);
    hit_edge = press_at + LAT;
    checkOutput("hit_shift_to_zero", expCat(), expDog(), 8'h00, 16'h0000);
    waitUntil(hit_edge + 1000);
    checkOutput("hit_exit2", expCat(), expDog(), 8'h18, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("zero_stays_zero", expCat(), expDog(), 8'h00, 16'h0000);

    // Win: park rat at column 0, which stays clear of both patrols for a long window
    doReset();
    startPlay();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("win_rat_parked", expCat(), expDog(), 8'h03, 16'h0000);
    waitUntil(go_edge + 620);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (i == 15) begin
        frozen_n = press_at + LAT - go_edge;
        pmode = 2;
      end
      checkOutput($sformatf("win_fill[%0d]", i), expCat(), expDog(), 8'h03,
                  16'((32'h1 << (i + 1)) - 1));
    end
    tick(700);
    checkOutput("win_frozen", expCat(), expDog(), 8'h03, 16'hffff);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("win_no_move", expCat(), expDog(), 8'h03, 16'hffff);
    applyStimulus(1'b0, 1'b0, 1'b1);
    go_edge = press_at + LAT;
    pmode = 1;
    checkOutput("win_restart", 8'h03, 8'hC0, 8'h18, 16'h0000);

    // Short versus long button pulses
    doReset();
    startPlay();
    btn_right = 1'b1;
    tick(10);
    btn_right = 1'b0;
    tick(50);
`ifdef DEBOUNCE_EN
    checkOutput("short_pulse", expCat(), expDog(), 8'h18, 16'h0000);
`else
    checkOutput("short_pulse", expCat(), expDog(), 8'h30, 16'h0000);
`endif
    btn_right = 1'b1;
    tick(30);
    btn_right = 1'b0;
    tick(50);
`ifdef DEBOUNCE_EN
    checkOutput("long_pulse", expCat(), expDog(), 8'h30, 16'h0000);
`else
    checkOutput("long_pulse", expCat(), expDog(), 8'h60, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
